// File: rtl/wb_arbiter2.sv
// Two-master round-robin arbiter for the 8-bit data / 24-bit address bus; grant is held for a whole cyc.
// Optional stalled-strobe watchdog is compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_rw,
    input  logic [23:0] i_m0_addr,
    input  logic [7:0]  i_m0_dat,
    output logic [7:0]  o_m0_dat,
    output logic        o_m0_ack,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_rw,
    input  logic [23:0] i_m1_addr,
    input  logic [7:0]  i_m1_dat,
    output logic [7:0]  o_m1_dat,
    output logic        o_m1_ack,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    output logic        o_s_rw,
    output logic [23:0] o_s_addr,
    output logic [7:0]  o_s_dat,
    input  logic [7:0]  i_s_dat,
    input  logic        i_s_ack,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;     // 0 = M0 owned last, 1 = M1 owned last
    logic   own_stb;
    logic   timeout_hit;

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (i_m0_cyc) begin
                    state_d = OWN0;
                end else if (i_m1_cyc) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!i_m0_cyc) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            OWN1: begin
                if (!i_m1_cyc) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign own_stb = ((state_q == OWN0) && i_m0_stb) || ((state_q == OWN1) && i_m1_stb);

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    assign timeout_hit = own_stb && (tmo_cnt_q == 8'(TIMEOUT));
    assign o_timeout   = timeout_hit;

    always_comb begin
        if (timeout_hit || !own_stb || i_s_ack) begin
            tmo_cnt_d = 8'd0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic [7:0] timeout_unused;

    assign timeout_unused = 8'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign o_timeout      = 1'b0;
`endif

    // Acks are only forwarded while the owner strobes; a watchdog expiry substitutes an 0xFF ack.
    always_comb begin
        o_grant  = 2'b00;
        o_s_cyc  = 1'b0;
        o_s_stb  = 1'b0;
        o_s_rw   = 1'b1;
        o_s_addr = 24'h0;
        o_s_dat  = 8'h0;
        o_m0_ack = 1'b0;
        o_m0_dat = 8'h0;
        o_m1_ack = 1'b0;
        o_m1_dat = 8'h0;
        case (state_q)
            OWN0: begin
                o_grant  = 2'b01;
                o_s_cyc  = i_m0_cyc;
                o_s_stb  = i_m0_stb && !timeout_hit;
                o_s_rw   = i_m0_rw;
                o_s_addr = i_m0_addr;
                o_s_dat  = i_m0_dat;
                o_m0_ack = (i_s_ack && i_m0_stb) || timeout_hit;
                o_m0_dat = timeout_hit ? 8'hFF : i_s_dat;
            end
            OWN1: begin
                o_grant  = 2'b10;
                o_s_cyc  = i_m1_cyc;
                o_s_stb  = i_m1_stb && !timeout_hit;
                o_s_rw   = i_m1_rw;
                o_s_addr = i_m1_addr;
                o_s_dat  = i_m1_dat;
                o_m1_ack = (i_s_ack && i_m1_stb) || timeout_hit;
                o_m1_dat = timeout_hit ? 8'hFF : i_s_dat;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Scoreboard bench for wb_arbiter2: two master drivers, a random-latency slave and a rule-level ownership model.
// Watchdog expectations switch on with WB_ARB_TIMEOUT_EN (TIMEOUT overridden to 4).
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_rw  [2];
    logic [23:0] m_addr [2];
    logic [7:0]  m_dat  [2];
    logic [7:0]  m0_rdat, m1_rdat;
    logic        m0_ack, m1_ack;
    logic        s_cyc, s_stb, s_rw;
    logic [23:0] s_addr;
    logic [7:0]  s_wdat;
    logic [7:0]  s_dat = 8'h00;
    logic        s_ack = 1'b0;
    logic [1:0]  grant;
    logic        timeout;

    wb_arbiter2 #(.TIMEOUT(4)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_m0_cyc   (m_cyc[0]),
        .i_m0_stb   (m_stb[0]),
        .i_m0_rw    (m_rw[0]),
        .i_m0_addr  (m_addr[0]),
        .i_m0_dat   (m_dat[0]),
        .o_m0_dat   (m0_rdat),
        .o_m0_ack   (m0_ack),
        .i_m1_cyc   (m_cyc[1]),
        .i_m1_stb   (m_stb[1]),
        .i_m1_rw    (m_rw[1]),
        .i_m1_addr  (m_addr[1]),
        .i_m1_dat   (m_dat[1]),
        .o_m1_dat   (m1_rdat),
        .o_m1_ack   (m1_ack),
        .o_s_cyc    (s_cyc),
        .o_s_stb    (s_stb),
        .o_s_rw     (s_rw),
        .o_s_addr   (s_addr),
        .o_s_dat    (s_wdat),
        .i_s_dat    (s_dat),
        .i_s_ack    (s_ack),
        .o_grant    (grant),
        .o_timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] addr;
        logic [7:0]  dat;
        logic        rw;
    } req_t;

    req_t       req_q0 [$];
    req_t       req_q1 [$];
    logic [7:0] rsp_q0 [$];
    logic [7:0] rsp_q1 [$];
    logic [1:0] hist   [$];

    int         checks = 0;
    int         errors = 0;
    bit         mute = 1'b1;
    bit         mon_en = 1'b0;
    int         ref_owner = -1;
    int         ref_last = 1;
    logic [1:0] prev_grant = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant transitions seen so far, packed as {count, 2 bits per entry}.
    function automatic logic [31:0] hist_code();
        logic [23:0] v;
        v = 24'h0;
        foreach (hist[i]) v = {v[21:0], hist[i]};
        return {8'(hist.size()), v};
    endfunction

    // Ownership rules: idle grants the lone requester, a tie goes to whoever did not own last,
    // and an owner keeps the bus until it drops cyc.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_owner <= -1;
            ref_last  <= 1;
        end else if (ref_owner < 0) begin
            if (m_cyc[0] && m_cyc[1]) ref_owner <= 1 - ref_last;
            else if (m_cyc[0])        ref_owner <= 0;
            else if (m_cyc[1])        ref_owner <= 1;
        end else if (!m_cyc[ref_owner]) begin
            ref_last  <= ref_owner;
            ref_owner <= -1;
        end
    end

    // Monitor: compares every cycle and pops the scoreboard whenever the DUT acks.
    initial begin
        int         o;
        logic [1:0] exp_g;
        logic [7:0] own_rdat;
        req_t       r;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (grant != prev_grant) begin
                    hist.push_back(grant);
                    prev_grant = grant;
                end
                exp_g = (ref_owner == 0) ? 2'b01 : (ref_owner == 1) ? 2'b10 : 2'b00;
                chk("grant", 64'(grant), 64'(exp_g));
`ifndef WB_ARB_TIMEOUT_EN
                chk("no_timeout", 64'(timeout), 64'(0));
`endif
                if (ref_owner < 0) begin
                    chk("idle_outputs",
                        64'({s_cyc, s_stb, s_rw, m0_ack, m1_ack, s_addr, s_wdat, m0_rdat, m1_rdat}),
                        64'({5'b00100, 24'h0, 8'h0, 8'h0, 8'h0}));
                end else begin
                    o = ref_owner;
                    own_rdat = (o == 0) ? m0_rdat : m1_rdat;
`ifdef WB_ARB_TIMEOUT_EN
                    if (!timeout)
`endif
                        chk("routing",
                            64'({s_cyc, s_stb, s_rw, s_addr, s_wdat, own_rdat}),
                            64'({m_cyc[o], m_stb[o], m_rw[o], m_addr[o], m_dat[o], s_dat}));
                    if (o == 0) chk("nonowner_m1", 64'({m1_ack, m1_rdat}), 64'(0));
                    else        chk("nonowner_m0", 64'({m0_ack, m0_rdat}), 64'(0));
                    if (s_ack && s_stb) begin
                        if ((o == 0 && req_q0.size() == 0) || (o == 1 && req_q1.size() == 0)) begin
                            chk("slave_req_unexpected", 64'(1), 64'(0));
                        end else begin
                            r = (o == 0) ? req_q0.pop_front() : req_q1.pop_front();
                            chk("slave_req", 64'({s_addr, s_wdat, s_rw}), 64'(r));
                        end
                    end
                end
                if (m0_ack) begin
                    if (rsp_q0.size() == 0) chk("m0_ack_unexpected", 64'(1), 64'(0));
                    else                    chk("m0_rdata", 64'(m0_rdat), 64'(rsp_q0.pop_front()));
                end
                if (m1_ack) begin
                    if (rsp_q1.size() == 0) chk("m1_ack_unexpected", 64'(1), 64'(0));
                    else                    chk("m1_rdata", 64'(m1_rdat), 64'(rsp_q1.pop_front()));
                end
            end
        end
    end

    // Slave: acks each new strobe 1..3 cycles later with random data.
    initial begin
        int lat;
        forever begin
            @(negedge clk);
            if (!mute && rst_n && s_stb && !s_ack) begin
                lat = int'($urandom_range(0, 2));
                repeat (lat) @(negedge clk);
                @(posedge clk);
                #1;
                s_ack = 1'b1;
                s_dat = 8'($urandom);
                if (ref_owner == 0)      rsp_q0.push_back(s_dat);
                else if (ref_owner == 1) rsp_q1.push_back(s_dat);
                @(posedge clk);
                #1;
                s_ack = 1'b0;
            end
        end
    end

    task automatic push_req(input int m, input logic [23:0] a, input logic [7:0] d, input logic rw);
        req_t r;
        r.addr = a;
        r.dat  = d;
        r.rw   = rw;
        if (m == 0) req_q0.push_back(r);
        else        req_q1.push_back(r);
    endtask

    // One master cycle of n strobes; directed mode writes 0xA5 to base, base+1, ...
    task automatic burst(input int m, input int n, input logic [23:0] base, input bit rnd);
        int waited;
        bit got;
        @(posedge clk);
        #1;
        m_cyc[m] = 1'b1;
        for (int k = 0; k < n; k++) begin
            m_stb[m] = 1'b1;
            if (rnd) begin
                m_addr[m] = 24'($urandom);
                m_dat[m]  = 8'($urandom);
                m_rw[m]   = 1'($urandom);
            end else begin
                m_addr[m] = base + 24'(k);
                m_dat[m]  = 8'hA5;
                m_rw[m]   = 1'b0;
            end
            push_req(m, m_addr[m], m_dat[m], m_rw[m]);
            waited = 0;
            got = 1'b0;
            while (!got && waited < 300) begin
                @(negedge clk);
                got = (m == 0) ? m0_ack : m1_ack;
                waited++;
            end
            if (!got) chk("ack_wait_expired", 64'(1), 64'(0));
            @(posedge clk);
            #1;
            m_stb[m] = 1'b0;
            if (rnd && k < n - 1) begin
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        m_cyc[m] = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_rw[i] = 1'b1;
            m_addr[i] = 24'h0; m_dat[i] = 8'h0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", 64'({grant, s_cyc, s_stb, s_rw, m0_ack, m1_ack, timeout}),
            64'({2'b00, 1'b0, 1'b0, 1'b1, 3'b000}));
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        settle(2);

        // Single M0 read of 0x001234, slave answers 0x5A two cycles after the strobe.
        hist.delete();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_rw[0] = 1'b1; m_addr[0] = 24'h001234; m_dat[0] = 8'h00;
        push_req(0, 24'h001234, 8'h00, 1'b1);
        @(negedge clk);
        chk("t1_grant_latency", 64'(s_cyc), 64'(0));
        @(negedge clk);
        chk("t1_slave_addr", 64'({s_cyc, s_stb, s_addr}), 64'({1'b1, 1'b1, 24'h001234}));
        settle(1);
        @(posedge clk);
        #1;
        s_ack = 1'b1; s_dat = 8'h5A;
        rsp_q0.push_back(8'h5A);
        @(negedge clk);
        chk("t1_read_ack", 64'({m0_ack, m0_rdat, m1_ack}), 64'({1'b1, 8'h5A, 1'b0}));
        @(posedge clk);
        #1;
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        settle(3);
        chk("t1_grant_seq", 64'(hist_code()), 64'({8'd2, 24'h000004}));

        // Simultaneous requests straight out of reset.
        rst_n = 1'b0;
        settle(1);
        rst_n = 1'b1;
        settle(1);
        hist.delete();
        prev_grant = 2'b00;
        mute = 1'b0;
        fork
            burst(0, 1, 24'h000100, 1'b0);
            burst(1, 1, 24'h000200, 1'b0);
        join
        settle(4);
        chk("t2_grant_seq", 64'(hist_code()), 64'({8'd4, 24'h000048}));

        // Round-robin after an M1 write of 0xA5 to 0x00FF00.
        hist.delete();
        burst(1, 1, 24'h00FF00, 1'b0);
        fork
            burst(0, 1, 24'h000300, 1'b0);
            burst(1, 1, 24'h000310, 1'b0);
        join
        settle(4);
        chk("t3_grant_seq", 64'(hist_code()), 64'({8'd6, 24'h000848}));

        // M1 holds cyc across three strobes while M0 waits.
        hist.delete();
        fork
            burst(1, 3, 24'h000010, 1'b0);
            begin
                settle(2);
                burst(0, 1, 24'h000400, 1'b0);
            end
        join
        settle(4);
        chk("t4_grant_seq", 64'(hist_code()), 64'({8'd4, 24'h000084}));

        // Asynchronous reset in the middle of an owned strobe.
        mute = 1'b1;
        settle(2);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_rw[0] = 1'b1; m_addr[0] = 24'h000500;
        @(negedge clk);
        @(negedge clk);
        chk("t5_owned", 64'({s_cyc, s_stb}), 64'(2'b11));
        #2 rst_n = 1'b0;
        #1 chk("t5_async_reset", 64'({s_cyc, s_stb, m0_ack, grant}), 64'(0));
        @(posedge clk);
        #1;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        settle(1);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 24'h000600;
        @(negedge clk);
        chk("t5_regrant_c0", 64'(grant), 64'(2'b00));
        @(negedge clk);
        chk("t5_regrant_c1", 64'(grant), 64'(2'b01));

        // Slave never acks: the watchdog answers after 4 stall cycles, otherwise nothing.
`ifdef WB_ARB_TIMEOUT_EN
        rsp_q0.push_back(8'hFF);
`endif
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
            if (i == 5) chk("t6_timeout_ack", 64'({m0_ack, m0_rdat, timeout, s_stb}),
                            64'({1'b1, 8'hFF, 1'b1, 1'b0}));
            else        chk("t6_timeout_wait", 64'({m0_ack, timeout, s_stb}), 64'(3'b001));
`else
            chk("t6_no_ack", 64'({m0_ack, timeout, s_stb}), 64'(3'b001));
`endif
        end
        @(posedge clk);
        #1;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        settle(3);

        // Random contention between both masters.
        mute = 1'b0;
        fork
            repeat (8) begin
                settle(int'($urandom_range(0, 3)));
                burst(0, int'($urandom_range(1, 4)), 24'h0, 1'b1);
            end
            repeat (8) begin
                settle(int'($urandom_range(0, 3)));
                burst(1, int'($urandom_range(1, 4)), 24'h0, 1'b1);
            end
        join
        settle(6);
        chk("scoreboard_drain",
            64'(req_q0.size() + req_q1.size() + rsp_q0.size() + rsp_q1.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
